// File: rtl/lookup_tbl_ctrl_if.sv
// Lookup/config bus for the lookup table controller.
// master = packet source + config requester, slave = the controller.
interface lookup_tbl_ctrl_if #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  datavalid;
  logic                  in_ready;
  logic [CTRL_WIDTH-1:0] in_ctl;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_wr;
  logic [CTRL_WIDTH-1:0] out_ctl;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  cfg_req;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [3:0]            cfg_wdata;
  logic                  cfg_ack;
  logic                  init_done;

  modport master (
    output datavalid, in_ctl, in_data, cfg_req, cfg_addr, cfg_wdata,
    input  in_ready, out_wr, out_ctl, out_data, cfg_ack, init_done
  );

  modport slave (
    input  datavalid, in_ctl, in_data, cfg_req, cfg_addr, cfg_wdata,
    output in_ready, out_wr, out_ctl, out_data, cfg_ack, init_done
  );
endinterface

// File: rtl/lookup_tbl_ctrl.sv
// Lookup table controller: a small 4-bit action/next-pointer table indexed
// by a key field of the packet. Packet lookups have priority; a config write
// waits for an idle datapath cycle and is forced after MAX_DEFER busy cycles.
module lookup_tbl_ctrl #(
  parameter int          DATA_WIDTH    = 480,
  parameter int          CTRL_WIDTH    = 32,
  parameter int          ADDR_WIDTH    = 4,
  parameter int          KEY_LSB       = 207,
  parameter int          MAX_DEFER     = 8,
  parameter logic [3:0]  DEFAULT_ENTRY = 4'b1011
) (
  input logic                clk,
  input logic                rst,
  lookup_tbl_ctrl_if.slave   bus
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int DEFER_W = (MAX_DEFER < 2) ? 1 : $clog2(MAX_DEFER + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = {ADDR_WIDTH{1'b1}};
  localparam logic [DEFER_W-1:0]    DEFER_LAST = DEFER_W'(MAX_DEFER);
  localparam logic [DEFER_W-1:0]    DEFER_ONE  = DEFER_W'(1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DEFER,
    ST_FORCE,
    ST_ACK
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [DEFER_W-1:0]    defer_cnt;
  logic                  in_ready_q;
  logic                  cfg_ack_q;
  logic                  init_done_q;

  logic [3:0]            table_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] key;
  logic [3:0]            lookup_entry;
  logic                  lookup_fire;
  logic [CTRL_WIDTH-1:0] ctl_next;

  logic                  out_wr_q;
  logic [CTRL_WIDTH-1:0] out_ctl_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // Only the key field and the two forwarded control bytes are consumed.
  logic unused_ctl_bits;
  assign unused_ctl_bits = ^{bus.in_ctl[23:16], bus.in_ctl[7:0]};

  assign key          = bus.in_data[KEY_LSB +: ADDR_WIDTH];
  assign lookup_entry = table_mem[key];
  assign lookup_fire  = bus.datavalid && in_ready_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.cfg_ack   = cfg_ack_q;
  assign bus.init_done = init_done_q;
  assign bus.out_wr    = out_wr_q;
  assign bus.out_ctl   = out_ctl_q;
  assign bus.out_data  = out_data_q;

  // Assemble the outgoing control word from the entry and forwarded in_ctl bytes.
  always_comb begin
    ctl_next        = '0;
    ctl_next[1:0]   = lookup_entry[1:0];
    ctl_next[17:16] = lookup_entry[3:2];
    ctl_next[15:8]  = bus.in_ctl[15:8];
    ctl_next[31:24] = bus.in_ctl[31:24];
  end

  // Controller FSM: table init, config write arbitration and the table write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      defer_cnt   <= '0;
      in_ready_q  <= 1'b0;
      cfg_ack_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      cfg_ack_q <= 1'b0;
      case (state)
        ST_INIT: begin
          table_mem[init_cnt] <= DEFAULT_ENTRY;
          if (init_cnt == LAST_IDX) begin
            state       <= ST_IDLE;
            init_cnt    <= '0;
            init_done_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (bus.cfg_req) begin
            if (bus.datavalid) begin
              state     <= ST_DEFER;
              defer_cnt <= DEFER_ONE;
            end else begin
              table_mem[bus.cfg_addr] <= bus.cfg_wdata;
              state     <= ST_ACK;
              cfg_ack_q <= 1'b1;
            end
          end
        end
        ST_DEFER: begin
          if (!bus.datavalid) begin
            table_mem[bus.cfg_addr] <= bus.cfg_wdata;
            state     <= ST_ACK;
            cfg_ack_q <= 1'b1;
            defer_cnt <= '0;
          end else if (defer_cnt == DEFER_LAST) begin
            state      <= ST_FORCE;
            in_ready_q <= 1'b0;
            defer_cnt  <= '0;
          end else begin
            defer_cnt <= defer_cnt + DEFER_ONE;
          end
        end
        ST_FORCE: begin
          table_mem[bus.cfg_addr] <= bus.cfg_wdata;
          state      <= ST_ACK;
          cfg_ack_q  <= 1'b1;
          in_ready_q <= 1'b1;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_INIT;
          init_cnt   <= '0;
          defer_cnt  <= '0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Lookup datapath: register the result one cycle after an accepted lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr_q   <= 1'b0;
      out_ctl_q  <= '0;
      out_data_q <= '0;
    end else if (lookup_fire) begin
      out_wr_q   <= 1'b1;
      out_ctl_q  <= ctl_next;
      out_data_q <= bus.in_data;
    end else begin
      out_wr_q <= 1'b0;
    end
  end

endmodule
